// File: rtl/ring_pkg.sv
// Shared constants and header helpers for the 160-bit agent message ring.
package ring_pkg;

  localparam int MSG_W     = 160;
  localparam int ID_W      = 8;
  localparam int HDR_W     = 32;
  localparam int PAYLOAD_W = MSG_W - HDR_W;

  localparam int DST_LSB  = 0;
  localparam int SRC_LSB  = 8;
  localparam int SEQ_LSB  = 16;
  localparam int KIND_LSB = 24;

  localparam logic [ID_W-1:0] KIND_NONE = 8'h00;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // A message is present on a link whenever its header is nonzero.
  function automatic logic msg_valid(input logic [MSG_W-1:0] m);
    return m[HDR_W-1:0] != '0;
  endfunction

  function automatic logic [ID_W-1:0] msg_dst(input logic [MSG_W-1:0] m);
    return m[DST_LSB +: ID_W];
  endfunction

endpackage

// File: rtl/ring_fifo.sv
// Synchronous FIFO; a push into a full FIFO is taken when a pop happens on the same edge.
module ring_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ring_endpoint.sv
// Host-side ring endpoint: tags and sends host requests, terminates the ring and delivers local messages.
//   state   | meaning
//   TX_IDLE | msgout is 0; waiting for a queued request while en is high
//   TX_SEND | msgout holds a message until okin; stall timer runs down while okin is low
module ring_endpoint
  import ring_pkg::*;
#(
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_W-1:0]      localid,
  input  logic                 en,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [ID_W-1:0]      tx_dst,
  input  logic [ID_W-1:0]      tx_kind,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic [MSG_W-1:0]     msgout,
  input  logic                 okin,
  input  logic [MSG_W-1:0]     msgin,
  output logic                 okout,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [MSG_W-1:0]     rx_msg,
  output logic [15:0]          stray_cnt,
  output logic                 stall_err,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(1);

  tx_state_t        state;
  logic [ID_W-1:0]  seq;
  logic [TW-1:0]    timer;
  logic [MSG_W-1:0] tx_entry;
  logic [MSG_W-1:0] tx_head;
  logic             tx_full, tx_empty, tx_push, load_next, xfer_out;
  logic             rx_full, rx_empty, rx_capture, rx_push;

  always_comb begin
    tx_entry                          = '0;
    tx_entry[DST_LSB  +: ID_W]        = tx_dst;
    tx_entry[SRC_LSB  +: ID_W]        = localid;
    tx_entry[SEQ_LSB  +: ID_W]        = seq;
    tx_entry[KIND_LSB +: ID_W]        = tx_kind;
    tx_entry[HDR_W    +: PAYLOAD_W]   = tx_data;
  end

  assign tx_ready  = !tx_full;
  assign tx_push   = tx_valid && tx_ready && (tx_kind != KIND_NONE);
  assign xfer_out  = msg_valid(msgout) && okin;
  assign load_next = !tx_empty && en && ((state == TX_IDLE) || xfer_out);

  ring_fifo #(.WIDTH(MSG_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_entry),
    .pop       (load_next),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      msgout    <= '0;
      timer     <= '0;
      stall_err <= 1'b0;
      seq       <= '0;
    end else begin
      if (tx_push) seq <= seq + 1'b1;
      case (state)
        TX_IDLE: begin
          if (load_next) begin
            msgout <= tx_head;
            timer  <= TIMER_LOAD;
            state  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (xfer_out) begin
            if (load_next) begin
              msgout <= tx_head;
              timer  <= TIMER_LOAD;
            end else begin
              msgout <= '0;
              state  <= TX_IDLE;
            end
          end else begin
            // The message stays on the ring after a timeout; only the flag reports it.
            if (timer != '0) timer <= timer - 1'b1;
            if (timer == TIMER_LAST) stall_err <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  // okout toggles low after every capture, so the ring delivers at most one message per two cycles.
  assign rx_capture = msg_valid(msgin) && okout;
  assign rx_push    = rx_capture && (msg_dst(msgin) == localid);
  assign rx_valid   = !rx_empty;

  ring_fifo #(.WIDTH(MSG_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (msgin),
    .pop       (rx_valid && rx_ready),
    .head      (rx_msg),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      okout     <= 1'b0;
      stray_cnt <= '0;
    end else begin
      okout <= msg_valid(msgin) && !okout && !rx_full;
      if (rx_capture && !rx_push && (stray_cnt != 16'hFFFF))
        stray_cnt <= stray_cnt + 1'b1;
    end
  end

  assign busy = !tx_empty || msg_valid(msgout) || !rx_empty;

endmodule
